// File: rtl/multiplier_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM states and the
// helper that sizes the double-width product.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit width of the product of two operands of the given width.
  function automatic int mul_width_t(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/twos_magnitude.sv
// Conditional two's-complement negation: yields |value| for a signed operand
// whose MSB is set, or the negation of value when force_neg is asserted.
module twos_magnitude #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  input  logic             force_neg,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign      = (is_signed & value[WIDTH-1]) | force_neg;
  // -2^(WIDTH-1) maps onto itself, which read unsigned is the correct magnitude.
  assign magnitude = sign ? WIDTH'(~value + 1'b1) : value;

endmodule

// File: rtl/multiplier_nbits_seq.sv
// Parametrised sequential shift-add multiplier with S/PRONTO handshake,
// run-time signed mode and a BUSY status; one iteration per clock.
module multiplier_nbits_seq
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            S,
  input  logic                            SIGNED_MODE,
  input  logic [WIDTH-1:0]                w,
  input  logic [WIDTH-1:0]                y,
  output logic [mul_width_t(WIDTH)-1:0]   result,
  output logic                            PRONTO,
  output logic                            BUSY
);

  localparam int PW = mul_width_t(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  w_mag;
  logic [WIDTH-1:0]  y_mag;
  logic              w_sign;
  logic              y_sign;
  logic              neg;
  logic [PW:0]       acc;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     prod_final;
  logic              final_sign_unused;

  twos_magnitude #(.WIDTH(WIDTH)) u_mag_w (
    .value     (w),
    .is_signed (SIGNED_MODE),
    .force_neg (1'b0),
    .magnitude (w_mag),
    .sign      (w_sign)
  );

  twos_magnitude #(.WIDTH(WIDTH)) u_mag_y (
    .value     (y),
    .is_signed (SIGNED_MODE),
    .force_neg (1'b0),
    .magnitude (y_mag),
    .sign      (y_sign)
  );

  // The unsigned product magnitude is negated only when the operand signs differed.
  twos_magnitude #(.WIDTH(PW)) u_fix (
    .value     (acc[PW-1:0]),
    .is_signed (1'b0),
    .force_neg (neg),
    .magnitude (prod_final),
    .sign      (final_sign_unused)
  );

  assign sum    = acc[PW:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
  assign PRONTO = (state == DONE);
  assign BUSY   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (S) state_nx = CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE:    if (S) cnt <= CW'(WIDTH);
        CALC:    cnt <= cnt - CW'(1);
        FIX:     result <= prod_final;
        default: ;
      endcase
    end
  end

  // Datapath: operand capture and one add-then-shift step per CALC cycle.
  always_ff @(posedge CLK) begin
    case (state)
      IDLE: begin
        if (S) begin
          mcand  <= w_mag;
          mplier <= y_mag;
          neg    <= w_sign ^ y_sign;
          acc    <= '0;
        end
      end
      CALC: begin
        acc    <= {1'b0, sum, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multiplier_nbits_seq.sv
// Directed bench for multiplier_nbits_seq: vector table at WIDTH=8 plus
// hand-written sequences for mid-run changes, held start, reset and WIDTH=16.
module tb_multiplier_nbits_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        s;
  logic        sm;
  logic [7:0]  w;
  logic [7:0]  y;
  logic [15:0] result;
  logic        pronto;
  logic        busy;

  logic        s16;
  logic [15:0] w16;
  logic [15:0] y16;
  logic [31:0] r16;
  logic        p16;
  logic        b16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiplier_nbits_seq #(.WIDTH(8)) dut (
    .CLK(clk), .RESET(rst), .S(s), .SIGNED_MODE(sm), .w(w), .y(y),
    .result(result), .PRONTO(pronto), .BUSY(busy)
  );

  multiplier_nbits_seq #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .S(s16), .SIGNED_MODE(1'b0), .w(w16), .y(y16),
    .result(r16), .PRONTO(p16), .BUSY(b16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One 8-bit computation with a single-cycle start pulse. With disturb set,
  // operands, mode and S are changed partway through the run.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input bit disturb, input string tag);
    logic [15:0] prev;
    bit          busy_ok;
    bit          hold_ok;
    int          lat;
    prev    = result;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    lat     = 0;
    @(negedge clk);
    w = a; y = b; sm = m; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    while (lat < 40) begin
      if (pronto) break;
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) hold_ok = 1'b0;
      if (disturb && lat == 3) begin
        w = 8'd99; y = 8'd77; sm = ~m; s = 1'b1;
      end
      if (disturb && lat == 4) s = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_result"}, 32'(result), 32'(a_b_dummy(result)));
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy"}, {31'd0, busy_ok & busy}, 32'd1);
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, pronto, busy}, 32'd0);
  endtask

  // Identity helper; the expected product is compared by the caller.
  function automatic logic [15:0] a_b_dummy(input logic [15:0] r);
    return r;
  endfunction

  logic [15:0] exp_r;

  initial begin
    vecs[0] = '{8'd17,  8'd23,  1'b0, 16'h0187};
    vecs[1] = '{8'hFB,  8'd7,   1'b1, 16'hFFDD};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[4] = '{8'd0,   8'd200, 1'b0, 16'h0000};
    vecs[5] = '{8'd127, 8'h80,  1'b1, 16'hC080};
    vecs[6] = '{8'h80,  8'd2,   1'b0, 16'h0100};
    vecs[7] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[8] = '{8'd0,   8'hFB,  1'b1, 16'h0000};
    vecs[9] = '{8'd5,   8'd3,   1'b1, 16'h000F};

    rst = 1'b1; s = 1'b0; sm = 1'b0; w = '0; y = '0;
    s16 = 1'b0; w16 = '0; y16 = '0;
    repeat (2) @(negedge clk);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", {30'd0, pronto, busy}, 32'd0);
    check("reset_result16", r16, 32'd0);
    check("reset_flags16", {30'd0, p16, b16}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_value", i), 32'(result), 32'(vecs[i].exp));
    end

    // Operand/mode changes and a stray S during the run must be ignored.
    run8(8'd17, 8'd23, 1'b0, 1'b1, "disturb");
    check("disturb_value", 32'(result), 32'h0187);
    repeat (3) @(negedge clk);
    check("disturb_no_restart", {31'd0, busy}, 32'd0);

    // S held high: back-to-back results every WIDTH+3 cycles.
    begin
      int last;
      int npulse;
      last = 0;
      npulse = 0;
      @(negedge clk);
      w = 8'd17; y = 8'd23; sm = 1'b0; s = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (pronto) begin
          if (npulse > 0) check("held_period", 32'(i - last), 32'd11);
          check("held_value", 32'(result), 32'h0187);
          last = i;
          npulse++;
        end
      end
      check("held_pulses", 32'(npulse), 32'd3);
      s = 1'b0;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
      check("held_drain", {31'd0, busy}, 32'd0);
    end

    // Reset mid-computation discards the run and clears the outputs.
    @(negedge clk);
    w = 8'd17; y = 8'd23; sm = 1'b0; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_flags", {30'd0, pronto, busy}, 32'd0);
    check("midreset_result", 32'(result), 32'd0);
    run8(8'd3, 8'd4, 1'b0, 1'b0, "after_reset");
    check("after_reset_value", 32'(result), 32'd12);

    // WIDTH=16 instance.
    begin
      int lat;
      lat = 0;
      @(negedge clk);
      w16 = 16'd40000; y16 = 16'd50000; s16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s16 = 1'b0;
      while (!p16 && lat < 60) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("w16_latency", 32'(lat), 32'd17);
      check("w16_result", r16, 32'h77359400);
    end

    exp_r = result;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
